// File: rtl/sseg_pkg.sv
// Shared types and constants for the multiplexed 7-segment display driver.
package sseg_pkg;

  localparam logic [6:0] SEG_OFF = 7'h7F;
  localparam logic [3:0] AN_OFF  = 4'hF;

  typedef logic [1:0] digit_idx_t;

  typedef enum logic [1:0] {OFF, BLANK, DRIVE} scan_state_t;

  function automatic logic [3:0] an_onehot(input digit_idx_t idx);
    return ~(4'b0001 << idx);
  endfunction

endpackage

// File: rtl/sseg_scan_mux_slot_timer.sv
// N-bit slot timer with clear priority over enable; exposes the post-edge count.
module slot_timer #(
  parameter int N = 18
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_en,
  input  logic         i_clr,
  output logic [N-1:0] o_cnt_next,
  output logic         o_wrap
);

  logic [N-1:0] r_cnt;

  always_comb begin
    o_cnt_next = r_cnt;
    if (i_clr)     o_cnt_next = '0;
    else if (i_en) o_cnt_next = r_cnt + 1'b1;
  end

  assign o_wrap = i_en && (r_cnt == {N{1'b1}});

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_cnt <= '0;
    else       r_cnt <= o_cnt_next;
  end

endmodule

// File: rtl/sseg_scan_mux.sv
// 4-digit common-anode scan driver: per-frame pattern capture, blanked slot start,
// outputs registered from the post-edge state so they track cnt/digit with no lag.
module sseg_scan_mux
  import sseg_pkg::*;
#(
  parameter int N            = 18,
  parameter int BLANK_CYCLES = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        en_i,
  input  logic [27:0] digits_i,
  input  logic [3:0]  dp_i,
  output logic [3:0]  an_o,
  output logic [6:0]  sseg_o,
  output logic        dp_o,
  output logic [1:0]  digit_o,
  output logic        frame_o
);

  if (BLANK_CYCLES >= (1 << N)) begin : g_bad_blank
    $error("BLANK_CYCLES must be smaller than the slot length 2**N");
  end

  localparam logic [N-1:0] BLANK_C = BLANK_CYCLES[N-1:0];

  scan_state_t     r_state;
  digit_idx_t      r_digit;
  logic            r_armed;
  logic [3:0][6:0] r_shadow;
  logic [3:0]      r_shadow_dp;

  logic [N-1:0]    w_cnt_next;
  logic            w_wrap;
  logic            w_fs;
  digit_idx_t      w_digit_next;
  logic [3:0][6:0] w_shadow_next;
  logic [3:0]      w_dp_next;
  scan_state_t     w_state_next;

  slot_timer #(.N(N)) u_timer (
    .i_clk      (clk_i),
    .i_rst      (rst_i),
    .i_en       (en_i),
    .i_clr      (!en_i || r_armed),
    .o_cnt_next (w_cnt_next),
    .o_wrap     (w_wrap)
  );

  // Frame start: first enabled cycle after idle, or the (3, max) -> (0, 0) wrap.
  assign w_fs          = en_i && (r_armed || (r_digit == 2'd3 && w_wrap));
  assign w_shadow_next = w_fs ? digits_i : r_shadow;
  assign w_dp_next     = w_fs ? dp_i : r_shadow_dp;

  always_comb begin
    w_digit_next = r_digit;
    if (!en_i || r_armed) w_digit_next = '0;
    else if (w_wrap)      w_digit_next = r_digit + 2'd1;
  end

  always_comb begin
    w_state_next = r_state;
    if (!en_i) begin
      w_state_next = OFF;
    end else begin
      case (r_state)
        OFF:     w_state_next = (BLANK_CYCLES == 0) ? DRIVE : BLANK;
        BLANK:   if (w_cnt_next == BLANK_C) w_state_next = DRIVE;
        DRIVE:   if (w_wrap) w_state_next = (BLANK_CYCLES == 0) ? DRIVE : BLANK;
        default: w_state_next = OFF;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state     <= OFF;
      r_digit     <= '0;
      r_armed     <= 1'b1;
      r_shadow    <= {4{SEG_OFF}};
      r_shadow_dp <= 4'hF;
      an_o        <= AN_OFF;
      sseg_o      <= SEG_OFF;
      dp_o        <= 1'b1;
      digit_o     <= '0;
      frame_o     <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_digit     <= w_digit_next;
      r_armed     <= !en_i;
      r_shadow    <= w_shadow_next;
      r_shadow_dp <= w_dp_next;
      digit_o     <= w_digit_next;
      frame_o     <= w_fs;
      if (w_state_next == DRIVE) begin
        an_o   <= an_onehot(w_digit_next);
        sseg_o <= w_shadow_next[w_digit_next];
        dp_o   <= w_dp_next[w_digit_next];
      end else begin
        an_o   <= AN_OFF;
        sseg_o <= SEG_OFF;
        dp_o   <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sseg_scan_mux.sv
// Bench for sseg_scan_mux (N=4, BLANK_CYCLES=2): frame-time model plus directed literal checks.
`timescale 1ns/100ps
module tb_sseg_scan_mux;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        en_i;
  logic [27:0] digits_i;
  logic [3:0]  dp_i;
  logic [3:0]  an_o;
  logic [6:0]  sseg_o;
  logic        dp_o;
  logic [1:0]  digit_o;
  logic        frame_o;

  int n_chk  = 0;
  int n_fail = 0;

  sseg_scan_mux #(.N(4), .BLANK_CYCLES(2)) dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .en_i     (en_i),
    .digits_i (digits_i),
    .dp_i     (dp_i),
    .an_o     (an_o),
    .sseg_o   (sseg_o),
    .dp_o     (dp_o),
    .digit_o  (digit_o),
    .frame_o  (frame_o)
  );

  always #5 clk_i = ~clk_i;

  // Model: position within the 64-cycle frame since the last frame start.
  bit         on_m    = 0;
  bit         armed_m = 1;
  bit         frame_m = 0;
  int         t_m     = 0;
  logic [6:0] sh_m [4];
  logic [3:0] shdp_m  = 4'hF;

  always @(posedge clk_i or posedge rst_i) begin
    if (rst_i || !en_i) begin
      on_m = 0; armed_m = 1; frame_m = 0; t_m = 0;
      if (rst_i) begin
        for (int k = 0; k < 4; k++) sh_m[k] = 7'h7F;
        shdp_m = 4'hF;
      end
    end else begin
      on_m = 1;
      if (armed_m || t_m == 63) begin
        t_m = 0; frame_m = 1; armed_m = 0;
        for (int k = 0; k < 4; k++) sh_m[k] = digits_i[k*7 +: 7];
        shdp_m = dp_i;
      end else begin
        t_m = t_m + 1; frame_m = 0;
      end
    end
  end

  function automatic logic [14:0] exp_vec();
    int d, c;
    logic [1:0] di;
    logic [3:0] an;
    d  = t_m / 16;
    c  = t_m % 16;
    di = d[1:0];
    an = ~(4'b0001 << di);
    if (!on_m)  return {4'hF, 7'h7F, 1'b1, 2'd0, 1'b0};
    if (c < 2)  return {4'hF, 7'h7F, 1'b1, di, frame_m};
    return {an, sh_m[d], shdp_m[d], di, frame_m};
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, got, exp);
    end
  endtask

  always @(negedge clk_i) begin
    if (!rst_i)
      chk("scan", {17'd0, an_o, sseg_o, dp_o, digit_o, frame_o}, {17'd0, exp_vec()});
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk_i);
  endtask

  task automatic chk_drive(input string name, input logic [3:0] an, input logic [6:0] seg, input logic dp);
    chk({name, "_an"},  {28'd0, an_o},  {28'd0, an});
    chk({name, "_seg"}, {25'd0, sseg_o}, {25'd0, seg});
    chk({name, "_dp"},  {31'd0, dp_o},  {31'd0, dp});
  endtask

  initial begin
    rst_i = 1; en_i = 0; digits_i = '0; dp_i = 4'hF;
    step(2);
    chk_drive("reset", 4'hF, 7'h7F, 1'b1);
    chk("reset_frame", {31'd0, frame_o}, 32'd0);
    step(2);
    rst_i = 0;
    step(20);
    chk_drive("idle", 4'hF, 7'h7F, 1'b1);
    chk("idle_frame", {31'd0, frame_o}, 32'd0);

    digits_i = {7'h12, 7'h24, 7'h30, 7'h40}; dp_i = 4'b1110; en_i = 1;
    step(1);                                             // t=0
    chk("fs1_frame", {31'd0, frame_o}, 32'd1);
    chk("fs1_an", {28'd0, an_o}, 32'h0000000F);
    step(1);                                             // t=1
    chk("blank2_an", {28'd0, an_o}, 32'h0000000F);
    step(1);                                             // t=2
    chk_drive("d0", 4'b1110, 7'h40, 1'b0);
    step(16);                                            // t=18
    chk_drive("d1", 4'b1101, 7'h30, 1'b1);
    step(32);                                            // t=50
    chk_drive("d3", 4'b0111, 7'h12, 1'b1);
    chk("d3_idx", {30'd0, digit_o}, 32'd3);
    step(14);                                            // t=0 of frame 2
    chk("wrap_frame", {31'd0, frame_o}, 32'd1);
    chk("wrap_idx", {30'd0, digit_o}, 32'd0);
    step(20);                                            // t=20, digit-1 slot
    digits_i = '0;
    step(16);                                            // t=36
    chk_drive("tear_d2", 4'b1011, 7'h24, 1'b1);
    step(16);                                            // t=52
    chk_drive("tear_d3", 4'b0111, 7'h12, 1'b1);
    step(14);                                            // t=2 of frame 3
    chk_drive("new_d0", 4'b1110, 7'h00, 1'b0);

    step(37);                                            // t=39: digit 2, cnt 7
    chk("pre_dis_idx", {30'd0, digit_o}, 32'd2);
    en_i = 0;
    step(1);
    chk("dis_an", {28'd0, an_o}, 32'h0000000F);
    chk("dis_idx", {30'd0, digit_o}, 32'd0);
    step(3);
    en_i = 1;
    step(1);
    chk("reen_frame", {31'd0, frame_o}, 32'd1);
    chk("reen_an", {28'd0, an_o}, 32'h0000000F);
    step(1);
    chk("reen_an1", {28'd0, an_o}, 32'h0000000F);
    step(1);
    chk_drive("reen_d0", 4'b1110, 7'h00, 1'b0);

    step(3);                                             // t=5, DRIVE
    @(posedge clk_i);
    #1 rst_i = 1;
    #3 rst_i = 0;
    chk_drive("arst", 4'hF, 7'h7F, 1'b1);
    chk("arst_frame", {31'd0, frame_o}, 32'd0);
    step(1);
    step(1);
    chk("arst_fs", {31'd0, frame_o}, 32'd1);
    step(70);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
